// File: rtl/hazard_controller.sv
// -----------------------------------------------------------------------------
// hazard_controller
//   Pipeline hazard unit for a five-stage MIPS-style core. It tracks the
//   instructions in EX, MEM and WB in a small scoreboard and from it:
//     - detects data hazards against the instruction in ID and stalls,
//     - applies control-flow flushes (taken branch, jr, j/jal),
//     - selects ALU operand forwarding paths (optional feature),
//     - counts stall and flush cycles in saturating 16-bit counters.
//
//   Optional feature macro: HAZARD_FORWARDING_EN
//     defined   : EX operands forwarded from MEM (01) / WB (10); only a
//                 load in EX whose result ID needs causes a stall.
//     undefined : FwdA/FwdB tied to 00; ID stalls while any in-flight
//                 producer in EX, MEM or WB matches one of its sources.
//
//   Ports
//     Clk, Reset                  clock, asynchronous active-high reset
//     ID_Rs, ID_Rt, ID_UseRs/Rt   ID source registers and their use bits
//     ID_Dest, ID_RegWrite,
//     ID_MemRead                  ID destination / writes-reg / is-load
//     ID_Jump, EX_Jr, M_PCSrc     j/jal in ID, jr in EX, taken branch in MEM
//     PC_Write, IFID_Write        PC and IF/ID update enables
//     IFID_Flush, IDEX_Flush,
//     EXMEM_Flush                 bubble insertion on the next edge
//     FwdA, FwdB                  00 regfile, 01 EX/MEM, 10 MEM/WB
//     State                       00 BOOT, 01 RUN, 10 STALL, 11 FLUSH
//     StallCount, FlushCount      saturating event counters
// -----------------------------------------------------------------------------
module hazard_controller (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [4:0]  ID_Rs,
  input  logic [4:0]  ID_Rt,
  input  logic        ID_UseRs,
  input  logic        ID_UseRt,
  input  logic [4:0]  ID_Dest,
  input  logic        ID_RegWrite,
  input  logic        ID_MemRead,
  input  logic        ID_Jump,
  input  logic        EX_Jr,
  input  logic        M_PCSrc,
  output logic        PC_Write,
  output logic        IFID_Write,
  output logic        IFID_Flush,
  output logic        IDEX_Flush,
  output logic        EXMEM_Flush,
  output logic [1:0]  FwdA,
  output logic [1:0]  FwdB,
  output logic [1:0]  State,
  output logic [15:0] StallCount,
  output logic [15:0] FlushCount
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'b00,
    ST_RUN   = 2'b01,
    ST_STALL = 2'b10,
    ST_FLUSH = 2'b11
  } state_e;

  typedef struct packed {
    logic       valid;
    logic       regwrite;
    logic       memread;
    logic [4:0] dest;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       use_rs;
    logic       use_rt;
  } slot_t;

  // A slot produces a value for a source only if it really writes a
  // non-zero register and the consumer actually reads that source.
  function automatic logic slot_match(input slot_t s, input logic [4:0] src,
                                      input logic use_src);
    return s.valid && s.regwrite && (s.dest != 5'd0) && (s.dest == src) && use_src;
  endfunction

  state_e      state_q, state_d;
  logic        boot_arm_q, boot_arm_d;
  slot_t       ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  logic [15:0] stall_count_q, stall_count_d;
  logic [15:0] flush_count_q, flush_count_d;
  logic        hazard_stall;
  logic        stall_inc;
  logic        flush_inc;
  logic        unused_wb_bits;

  // The WB slot only needs its producer fields; its consumer fields retire.
  assign unused_wb_bits = ^{wb_q.memread, wb_q.rs, wb_q.rt, wb_q.use_rs, wb_q.use_rt};

  assign State      = state_q;
  assign StallCount = stall_count_q;
  assign FlushCount = flush_count_q;

  // Data-hazard detection and operand forwarding selection.
  always_comb begin
    hazard_stall = 1'b0;
    FwdA         = 2'b00;
    FwdB         = 2'b00;
`ifdef HAZARD_FORWARDING_EN
    // Only a load still in EX cannot be forwarded in time.
    hazard_stall = ex_q.memread &&
                   (slot_match(ex_q, ID_Rs, ID_UseRs) || slot_match(ex_q, ID_Rt, ID_UseRt));
    // The younger producer in MEM wins over the older one in WB.
    if (slot_match(mem_q, ex_q.rs, ex_q.use_rs)) begin
      FwdA = 2'b01;
    end else if (slot_match(wb_q, ex_q.rs, ex_q.use_rs)) begin
      FwdA = 2'b10;
    end else begin
      FwdA = 2'b00;
    end
    if (slot_match(mem_q, ex_q.rt, ex_q.use_rt)) begin
      FwdB = 2'b01;
    end else if (slot_match(wb_q, ex_q.rt, ex_q.use_rt)) begin
      FwdB = 2'b10;
    end else begin
      FwdB = 2'b00;
    end
`else
    // Without bypass paths ID waits until the producer has left WB.
    hazard_stall = slot_match(ex_q,  ID_Rs, ID_UseRs) || slot_match(ex_q,  ID_Rt, ID_UseRt) ||
                   slot_match(mem_q, ID_Rs, ID_UseRs) || slot_match(mem_q, ID_Rt, ID_UseRt) ||
                   slot_match(wb_q,  ID_Rs, ID_UseRs) || slot_match(wb_q,  ID_Rt, ID_UseRt);
`endif
  end

  // Control FSM next state and prioritised pipeline control outputs.
  always_comb begin
    PC_Write    = 1'b1;
    IFID_Write  = 1'b1;
    IFID_Flush  = 1'b0;
    IDEX_Flush  = 1'b0;
    EXMEM_Flush = 1'b0;
    state_d     = state_q;
    boot_arm_d  = boot_arm_q;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;
    case (state_q)
      ST_BOOT: begin
        // The first edge after reset release arms BOOT, the second leaves it.
        PC_Write    = 1'b0;
        IFID_Write  = 1'b0;
        IFID_Flush  = 1'b1;
        IDEX_Flush  = 1'b1;
        EXMEM_Flush = 1'b1;
        boot_arm_d  = 1'b1;
        state_d     = boot_arm_q ? ST_RUN : ST_BOOT;
      end
      ST_RUN, ST_STALL, ST_FLUSH: begin
        if (M_PCSrc) begin
          IFID_Flush  = 1'b1;
          IDEX_Flush  = 1'b1;
          EXMEM_Flush = 1'b1;
          flush_inc   = 1'b1;
          state_d     = ST_FLUSH;
        end else if (EX_Jr) begin
          IFID_Flush  = 1'b1;
          IDEX_Flush  = 1'b1;
          flush_inc   = 1'b1;
          state_d     = ST_FLUSH;
        end else if (hazard_stall) begin
          PC_Write    = 1'b0;
          IFID_Write  = 1'b0;
          IDEX_Flush  = 1'b1;
          stall_inc   = 1'b1;
          state_d     = ST_STALL;
        end else if (ID_Jump) begin
          IFID_Flush  = 1'b1;
          flush_inc   = 1'b1;
          state_d     = ST_FLUSH;
        end else begin
          state_d     = ST_RUN;
        end
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  // Scoreboard advance: flushed or stalled stages receive a bubble.
  always_comb begin
    ex_d  = '0;
    mem_d = '0;
    wb_d  = mem_q;
    if (IDEX_Flush) begin
      ex_d = '0;
    end else begin
      ex_d = '{valid: 1'b1, regwrite: ID_RegWrite, memread: ID_MemRead, dest: ID_Dest,
               rs: ID_Rs, rt: ID_Rt, use_rs: ID_UseRs, use_rt: ID_UseRt};
    end
    if (EXMEM_Flush) begin
      mem_d = '0;
    end else begin
      mem_d = ex_q;
    end
  end

  // Saturating event counters, at most one increment per cycle each.
  always_comb begin
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;
    if (stall_inc && (stall_count_q != 16'hFFFF)) begin
      stall_count_d = stall_count_q + 16'd1;
    end else begin
      stall_count_d = stall_count_q;
    end
    if (flush_inc && (flush_count_q != 16'hFFFF)) begin
      flush_count_d = flush_count_q + 16'd1;
    end else begin
      flush_count_d = flush_count_q;
    end
  end

  // State, scoreboard and counter registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q       <= ST_BOOT;
      boot_arm_q    <= 1'b0;
      ex_q          <= '0;
      mem_q         <= '0;
      wb_q          <= '0;
      stall_count_q <= 16'd0;
      flush_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      boot_arm_q    <= boot_arm_d;
      ex_q          <= ex_d;
      mem_q         <= mem_d;
      wb_q          <= wb_d;
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
// -----------------------------------------------------------------------------
// tb_hazard_controller
//   Directed bench for hazard_controller. A behavioural model keeps the last
//   three issued instructions by age (1 = in EX, 2 = in MEM, 3 = in WB) and
//   derives every control output from producer/consumer dependencies; all
//   DUT outputs are compared against it on each falling edge. Literal
//   expectations at scenario ends pin the model. Honours HAZARD_FORWARDING_EN.
// -----------------------------------------------------------------------------
module tb_hazard_controller;

`ifdef HAZARD_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Reset;
  logic [4:0]  ID_Rs, ID_Rt, ID_Dest;
  logic        ID_UseRs, ID_UseRt, ID_RegWrite, ID_MemRead;
  logic        ID_Jump, EX_Jr, M_PCSrc;
  logic        PC_Write, IFID_Write, IFID_Flush, IDEX_Flush, EXMEM_Flush;
  logic [1:0]  FwdA, FwdB, State;
  logic [15:0] StallCount, FlushCount;

  hazard_controller dut (
    .Clk(Clk), .Reset(Reset),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UseRs(ID_UseRs), .ID_UseRt(ID_UseRt),
    .ID_Dest(ID_Dest), .ID_RegWrite(ID_RegWrite), .ID_MemRead(ID_MemRead),
    .ID_Jump(ID_Jump), .EX_Jr(EX_Jr), .M_PCSrc(M_PCSrc),
    .PC_Write(PC_Write), .IFID_Write(IFID_Write), .IFID_Flush(IFID_Flush),
    .IDEX_Flush(IDEX_Flush), .EXMEM_Flush(EXMEM_Flush),
    .FwdA(FwdA), .FwdB(FwdB), .State(State),
    .StallCount(StallCount), .FlushCount(FlushCount)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] dest;
    logic       urs;
    logic       urt;
    logic       rw;
    logic       mr;
  } instr_t;

  instr_t hist [1:3];
  int     m_boot_left;
  int     stall_ev;
  int     flush_ev;
  logic [1:0] m_state;
  bit     last_stall;
  int     vectors = 0;
  int     miscompares = 0;

  instr_t nop, add3, add4, lw3, add433, w0, r0, p_sat;

  function automatic instr_t mk(input logic [4:0] rs, input logic [4:0] rt,
                                input logic [4:0] dest, input logic urs, input logic urt,
                                input logic rw, input logic mr);
    instr_t i;
    i.rs = rs; i.rt = rt; i.dest = dest; i.urs = urs; i.urt = urt; i.rw = rw; i.mr = mr;
    return i;
  endfunction

  // True when consumer c needs a value that producer p has not yet written back.
  function automatic bit depends(input instr_t p, input instr_t c);
    return p.rw && (p.dest != 5'd0) &&
           ((c.urs && (c.rs == p.dest)) || (c.urt && (c.rt == p.dest)));
  endfunction

  function automatic bit model_stall(input instr_t id);
    if (FWD) return hist[1].mr && depends(hist[1], id);
    return depends(hist[1], id) || depends(hist[2], id) || depends(hist[3], id);
  endfunction

  // Nearest older producer of the EX instruction's source wins.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src, input logic use_src);
    if (!FWD || !use_src || src == 5'd0) return 2'b00;
    if (hist[2].rw && hist[2].dest == src) return 2'b01;
    if (hist[3].rw && hist[3].dest == src) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [31:0] sat16(input int n);
    return (n > 65535) ? 32'd65535 : 32'(n);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // One cycle: drive ID/event inputs, compare at the falling edge, advance model.
  task automatic step(input instr_t id, input logic j, input logic jr, input logic pcs);
    bit boot, sraw;
    logic epcw, eifw;
    logic [2:0] efl;
    logic [1:0] nst;
    ID_Rs = id.rs; ID_Rt = id.rt; ID_Dest = id.dest;
    ID_UseRs = id.urs; ID_UseRt = id.urt; ID_RegWrite = id.rw; ID_MemRead = id.mr;
    ID_Jump = j; EX_Jr = jr; M_PCSrc = pcs;
    @(negedge Clk);
    boot = (m_boot_left > 0);
    sraw = model_stall(id);
    if (boot) begin
      epcw = 1'b0; eifw = 1'b0; efl = 3'b111; nst = (m_boot_left == 1) ? 2'b01 : 2'b00;
    end else if (pcs) begin
      epcw = 1'b1; eifw = 1'b1; efl = 3'b111; nst = 2'b11;
    end else if (jr) begin
      epcw = 1'b1; eifw = 1'b1; efl = 3'b110; nst = 2'b11;
    end else if (sraw) begin
      epcw = 1'b0; eifw = 1'b0; efl = 3'b010; nst = 2'b10;
    end else if (j) begin
      epcw = 1'b1; eifw = 1'b1; efl = 3'b100; nst = 2'b11;
    end else begin
      epcw = 1'b1; eifw = 1'b1; efl = 3'b000; nst = 2'b01;
    end
    chk("state", 32'(State), 32'(m_state));
    chk("pc_write", 32'(PC_Write), 32'(epcw));
    chk("ifid_write", 32'(IFID_Write), 32'(eifw));
    chk("flushes", 32'({IFID_Flush, IDEX_Flush, EXMEM_Flush}), 32'(efl));
    chk("fwda", 32'(FwdA), 32'(fwd_sel(hist[1].rs, hist[1].urs)));
    chk("fwdb", 32'(FwdB), 32'(fwd_sel(hist[1].rt, hist[1].urt)));
    chk("stall_count", 32'(StallCount), sat16(stall_ev));
    chk("flush_count", 32'(FlushCount), sat16(flush_ev));
    last_stall = !boot && !pcs && !jr && sraw;
    @(posedge Clk);
    if (!boot) begin
      if (last_stall) stall_ev++;
      if (pcs || jr || (!last_stall && j)) flush_ev++;
    end
    hist[3] = hist[2];
    hist[2] = (boot || pcs) ? nop : hist[1];
    hist[1] = (boot || pcs || jr || last_stall) ? nop : id;
    if (boot) m_boot_left--;
    m_state = nst;
    #1;
  endtask

  task automatic do_reset();
    ID_Rs = 5'd0; ID_Rt = 5'd0; ID_Dest = 5'd0; ID_UseRs = 1'b0; ID_UseRt = 1'b0;
    ID_RegWrite = 1'b0; ID_MemRead = 1'b0; ID_Jump = 1'b0; EX_Jr = 1'b0; M_PCSrc = 1'b0;
    Reset = 1'b1;
    #1;
    hist[1] = nop; hist[2] = nop; hist[3] = nop;
    m_boot_left = 2; stall_ev = 0; flush_ev = 0; m_state = 2'b00; last_stall = 1'b0;
    chk("rst_state", 32'(State), 32'd0);
    chk("rst_stall_count", 32'(StallCount), 32'd0);
    chk("rst_flush_count", 32'(FlushCount), 32'd0);
    chk("rst_fwd", 32'({FwdA, FwdB}), 32'd0);
    @(posedge Clk);
    #1;
    chk("rst_hold_enables", 32'({PC_Write, IFID_Write}), 32'd0);
    chk("rst_hold_flushes", 32'({IFID_Flush, IDEX_Flush, EXMEM_Flush}), 32'd7);
    Reset = 1'b0;
  endtask

  initial begin
    int n;
    nop    = '0;
    add3   = mk(5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0);
    add4   = mk(5'd3, 5'd5, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0);
    lw3    = mk(5'd1, 5'd0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1);
    add433 = mk(5'd3, 5'd3, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0);
    w0     = mk(5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    r0     = mk(5'd0, 5'd0, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0);
    p_sat  = mk(5'd1, 5'd0, 5'd1, 1'b1, 1'b0, 1'b1, 1'b1);

    // Dependent ALU pair: add $3,$1,$2 ; add $4,$3,$5
    do_reset();
    step(nop, 1'b0, 1'b0, 1'b0);
    step(nop, 1'b0, 1'b0, 1'b0);
    step(add3, 1'b0, 1'b0, 1'b0);
    n = 0;
    do begin step(add4, 1'b0, 1'b0, 1'b0); n++; end while (last_stall && n < 10);
    chk("pair_stalls", 32'(StallCount), FWD ? 32'd0 : 32'd3);
    chk("pair_fwda", 32'(FwdA), FWD ? 32'd1 : 32'd0);
    step(nop, 1'b0, 1'b0, 1'b0);
    step(nop, 1'b0, 1'b0, 1'b0);

    // Load-use: lw $3,0($1) ; add $4,$3,$3
    do_reset();
    step(nop, 1'b0, 1'b0, 1'b0);
    step(nop, 1'b0, 1'b0, 1'b0);
    step(lw3, 1'b0, 1'b0, 1'b0);
    n = 0;
    do begin step(add433, 1'b0, 1'b0, 1'b0); n++; end while (last_stall && n < 10);
    chk("lu_stalls", 32'(StallCount), FWD ? 32'd1 : 32'd3);
    chk("lu_fwda", 32'(FwdA), FWD ? 32'd2 : 32'd0);
    chk("lu_fwdb", 32'(FwdB), FWD ? 32'd2 : 32'd0);

    // Taken branch coincident with a load-use stall
    do_reset();
    step(nop, 1'b0, 1'b0, 1'b0);
    step(nop, 1'b0, 1'b0, 1'b0);
    step(lw3, 1'b0, 1'b0, 1'b0);
    step(add433, 1'b0, 1'b0, 1'b1);
    chk("br_state", 32'(State), 32'd3);
    chk("br_stall_count", 32'(StallCount), 32'd0);
    chk("br_flush_count", 32'(FlushCount), 32'd1);

    // Jump held off by a stall, then branch+jr priority, jr alone, jump alone
    step(lw3, 1'b0, 1'b0, 1'b0);
    n = 0;
    do begin step(add433, 1'b1, 1'b0, 1'b0); n++; end while (last_stall && n < 10);
    step(nop, 1'b0, 1'b1, 1'b1);
    step(nop, 1'b0, 1'b1, 1'b0);
    step(nop, 1'b1, 1'b0, 1'b0);
    chk("ctl_flush_count", 32'(FlushCount), 32'd5);
    chk("ctl_stall_count", 32'(StallCount), FWD ? 32'd1 : 32'd3);

    // Writer of $0 followed by a reader of $0
    do_reset();
    step(nop, 1'b0, 1'b0, 1'b0);
    step(nop, 1'b0, 1'b0, 1'b0);
    step(w0, 1'b0, 1'b0, 1'b0);
    step(r0, 1'b0, 1'b0, 1'b0);
    step(nop, 1'b0, 1'b0, 1'b0);
    chk("zero_fwd", 32'({FwdA, FwdB}), 32'd0);
    chk("zero_stalls", 32'(StallCount), 32'd0);

    // Reset asserted in the middle of a stall
    step(lw3, 1'b0, 1'b0, 1'b0);
    step(add433, 1'b0, 1'b0, 1'b0);
    chk("mid_stall_state", 32'(State), 32'd2);
    do_reset();
    step(nop, 1'b0, 1'b0, 1'b0);
    chk("boot_after_edge1", 32'(State), 32'd0);
    step(nop, 1'b0, 1'b0, 1'b0);
    chk("run_after_edge2", 32'(State), 32'd1);

    // Sustained stalls up to counter saturation
    do_reset();
    for (int c = 0; c < (FWD ? 3000 : 90000) && stall_ev < 65540; c++) begin
      step(p_sat, 1'b0, 1'b0, 1'b0);
    end
    chk("sat_stall_count", 32'(StallCount), FWD ? sat16(stall_ev) : 32'h0000FFFF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
